sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Raster-to-window front end for the edge-detection path. Accepts one 8-bit grey pixel per cycle in raster order and produces the 3x3 neighbourhood as nine parallel pixels, one window per accepted interior pixel. Its outputs wire directly to the nine pixel inputs of the Sobel core. It buffers two image lines internally and suppresses border windows.

## Interface

- IMG_W, 256: pixels per line; must be at least 3.
- IMG_H, 256: lines per frame; must be at least 3.
- DW, 8: pixel width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_in  in  DW  incoming pixel.
- pix_valid  in  1  pix_in is accepted this cycle. There is no backpressure.
- sof  in  1  start of frame. Qualified by pix_valid; marks pixel (0,0).
- w0..w8  out  DW each  window in row-major order. w0 = (r-1,c-1), w4 = centre (r,c), w8 = (r+1,c+1).
- win_valid  out  1  w0..w8 hold a valid interior window this cycle.
- frame_done  out  1  one-cycle pulse, coincident with the last window of a frame.

## Operation

- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the coordinate of the accepted pixel.
  - Both advance only on pix_valid.
  - col wraps to 0 and increments row.
- Line buffers, indexed by col:
  - lb_a holds line row-2; lb_b holds line row-1.
  - On each accepted pixel, read lb_a[col] and lb_b[col], then write lb_a[col] <= lb_b[col] and lb_b[col] <= pix_in (read-before-write).
- Column shift registers: three 3-deep registers (top/mid/bottom), fed by lb_a, lb_b and pix_in. They shift on every accepted pixel. The newest column becomes w2/w5/w8.
- Window validity: the window is valid when the accepted pixel (y,x) has y >= 2 and x >= 2; it is centred at (y-1,x-1).
  - Each frame produces (IMG_W-2)*(IMG_H-2) windows.
  - Windows straddling a line wrap are never flagged valid, whatever stale data the shift registers hold.
- State machine:
  - IDLE: pix_valid without sof is ignored. pix_valid & sof → FILL; that pixel is (0,0).
  - FILL: rows 0–1. No windows. At the first pixel of row 2 → RUN.
  - RUN: windows as above. Accepting pixel (IMG_H-1, IMG_W-1) → DONE.
  - DONE: one cycle, then IDLE. A pix_valid & sof in DONE is accepted as (0,0) of the next frame and goes to FILL.
- sof in FILL or RUN aborts the current frame. The pixel is taken as (0,0), the state goes to FILL, no frame_done is issued, and the line buffers are not cleared (stale contents are masked by the validity rule).
- Arithmetic: counters are $clog2(IMG_W) and $clog2(IMG_H) bits, unsigned, wrapping via explicit compare to IMG_W-1 and IMG_H-1.

## Timing

- Reset values:
  - win_valid = 0, frame_done = 0, w0..w8 = 0.
  - State IDLE, col = row = 0.
  - Line buffer contents are undefined.
- Latency: 1 cycle. A window is registered on the edge that accepts pixel (r+1,c+1); win_valid is high the following cycle, for exactly one cycle.
- Gaps: when pix_valid = 0, all state, counters and shift registers hold, and win_valid = 0 next cycle.
- Sustains one window per cycle at full input rate.
- frame_done is high in the same cycle as the last win_valid of a frame.
- rst_n asserted mid-frame takes effect immediately: outputs clear and the state returns to IDLE. A new sof is required after release.

## Structure

- Shared package img_pkg holds:
  - the state enum (IDLE/FILL/RUN/DONE);
  - pixel width DW;
  - a window typedef (array of 9 pixels) reused by the Sobel core wrapper.
- Sub-module sobel_linebuf: a single-port-read/single-write line RAM of depth IMG_W × DW with a same-cycle read-before-write. It is instantiated twice (lb_a, lb_b) and can be inferred as block RAM or registers.
- The top level holds the counters, FSM, shift registers and validity logic.

## Test plan

- **Ramp frame.** IMG_W = IMG_H = 4, pixel = row*16 + col, continuous valid.
  - First window, the cycle after 0x22 is accepted: w0..w8 = 00,01,02,10,11,12,20,21,22.
  - Exactly 4 windows, the last centred 0x22.
  - frame_done with the last window.
- **Gapped input.** Same frame with pix_valid toggling 1/0 and random 0–3 idle cycles.
  - Identical window sequence to the ramp frame.
  - win_valid never high on a cycle following an idle input cycle.
- **Stray input.** pix_valid without sof in IDLE for 10 cycles → no state change. Then a valid frame produces correct output.
- **Mid-frame sof.** sof at pixel (2,1) of a 4x4 frame, followed by a full new frame.
  - No frame_done for the aborted frame.
  - The new frame yields exactly 4 correct windows.
- **Mid-frame reset.** rst_n pulsed low mid-RUN for 1 cycle.
  - Outputs are 0 during the pulse.
  - The following pixels without sof are ignored.
  - The next frame is correct.
- **Back-to-back frames.** Two 8x5 frames with sof on the cycle after the last pixel.
  - 18 windows per frame.
  - Two frame_done pulses.
  - Second-frame windows contain no first-frame data.

Source files
------------

// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared types for the edge-detection image path.
//   DW       : default pixel width.
//   pixel_t  : one grey pixel.
//   window_t : 3x3 neighbourhood, index 0 = top-left, 4 = centre,
//              8 = bottom-right (row-major).
//   state_t  : raster front-end frame states.
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int DW = 8;

    typedef logic [DW-1:0] pixel_t;
    typedef pixel_t [8:0]  window_t;

    typedef enum logic [1:0] {
        IDLE,   // waiting for a start-of-frame pixel
        FILL,   // rows 0 and 1: priming the line buffers
        RUN,    // rows 2 and up: windows are produced
        DONE    // one cycle after the last pixel of a frame
    } state_t;

endpackage

// File: rtl/sobel_linebuf.sv
// ---------------------------------------------------------------------------
// sobel_linebuf
// One image line of pixels, indexed by column. Combinational read of the
// addressed entry; the write to the same entry lands on the clock edge, so a
// read and write of one address in the same cycle returns the old contents.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   addr   in   column index (shared by read and write)
//   wdata  in   pixel to store at addr
//   rdata  out  pixel currently stored at addr
// ---------------------------------------------------------------------------
module sobel_linebuf #(
    parameter  int DEPTH = 256,
    parameter  int DW    = img_pkg::DW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // NOTE: the storage array has no reset so it can map onto RAM; stale
    // contents are harmless because window validity never exposes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
// Raster-to-window front end: takes one grey pixel per cycle in raster order
// and presents the 3x3 neighbourhood of every interior pixel, one cycle after
// the pixel that completes it is accepted.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   pix_in      in   incoming pixel
//   pix_valid   in   pix_in is offered this cycle (no backpressure)
//   sof         in   start of frame, qualified by pix_valid; pixel is (0,0)
//   w0..w8      out  window, row-major; w4 is the centre
//   win_valid   out  w0..w8 hold a valid interior window
//   frame_done  out  pulse with the last window of a frame
// ---------------------------------------------------------------------------
module sobel_window_gen
    import img_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int DW    = img_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] w0,
    output logic [DW-1:0] w1,
    output logic [DW-1:0] w2,
    output logic [DW-1:0] w3,
    output logic [DW-1:0] w4,
    output logic [DW-1:0] w5,
    output logic [DW-1:0] w6,
    output logic [DW-1:0] w7,
    output logic [DW-1:0] w8,
    output logic          win_valid,
    output logic          frame_done
);

    localparam int            CW       = $clog2(IMG_W);
    localparam int            RW       = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          accept, is_last, win_hit;
    logic [DW-1:0] a_rd, b_rd;

    // Column shift registers; index 2 holds the newest column.
    logic [DW-1:0] top_sr [3];
    logic [DW-1:0] mid_sr [3];
    logic [DW-1:0] bot_sr [3];

    // A pixel is taken in FILL/RUN, or anywhere a new frame may start.
    // A sof pixel is always (0,0), regardless of where the counters stand.
    always_comb begin
        accept  = pix_valid && (sof || state == FILL || state == RUN);
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        is_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        // Requiring col >= 2 rejects windows whose shift registers still
        // hold columns from the end of the previous line.
        win_hit = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    // Line buffers: lb_a holds row-2, lb_b holds row-1. Each accepted pixel
    // ages lb_b's old entry into lb_a and stores the new pixel in lb_b.
    sobel_linebuf #(.DEPTH(IMG_W), .DW(DW)) u_lb_a (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (b_rd),
        .rdata (a_rd)
    );

    sobel_linebuf #(.DEPTH(IMG_W), .DW(DW)) u_lb_b (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (pix_in),
        .rdata (b_rd)
    );

    // NOTE: every signal this block drives gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FILL;
            end
            FILL: begin
                if (accept && !sof && cur_row == RW'(2)) state_nxt = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (sof)          state_nxt = FILL;
                    else if (is_last) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = accept ? FILL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                top_sr[i] <= '0;
                mid_sr[i] <= '0;
                bot_sr[i] <= '0;
            end
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                top_sr[0] <= top_sr[1];
                top_sr[1] <= top_sr[2];
                top_sr[2] <= a_rd;
                mid_sr[0] <= mid_sr[1];
                mid_sr[1] <= mid_sr[2];
                mid_sr[2] <= b_rd;
                bot_sr[0] <= bot_sr[1];
                bot_sr[1] <= bot_sr[2];
                bot_sr[2] <= pix_in;
            end
            win_valid  <= win_hit;
            frame_done <= accept && (state == RUN) && is_last;
        end
    end

    assign w0 = top_sr[0];
    assign w1 = top_sr[1];
    assign w2 = top_sr[2];
    assign w3 = mid_sr[0];
    assign w4 = mid_sr[1];
    assign w5 = mid_sr[2];
    assign w6 = bot_sr[0];
    assign w7 = bot_sr[1];
    assign w8 = bot_sr[2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
// Two instances: u_d0 is a 4x4 frame, u_d1 is an 8x5 frame. Expected windows
// are taken straight from the stored image as 3x3 neighbourhoods of each
// interior pixel.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]      pix0, pix1;
    logic            pv0, pv1, sof0, sof1;
    logic [8:0][7:0] wa0, wa1;
    logic            win_valid0, win_valid1, frame_done0, frame_done1;

    sobel_window_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix0), .pix_valid(pv0), .sof(sof0),
        .w0(wa0[0]), .w1(wa0[1]), .w2(wa0[2]), .w3(wa0[3]), .w4(wa0[4]),
        .w5(wa0[5]), .w6(wa0[6]), .w7(wa0[7]), .w8(wa0[8]),
        .win_valid(win_valid0), .frame_done(frame_done0)
    );

    sobel_window_gen #(.IMG_W(8), .IMG_H(5), .DW(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix1), .pix_valid(pv1), .sof(sof1),
        .w0(wa1[0]), .w1(wa1[1]), .w2(wa1[2]), .w3(wa1[3]), .w4(wa1[4]),
        .w5(wa1[5]), .w6(wa1[6]), .w7(wa1[7]), .w8(wa1[8]),
        .win_valid(win_valid1), .frame_done(frame_done1)
    );

    int checks = 0;
    int failures = 0;

    // Window packed with w0 in the most significant byte.
    function automatic logic [71:0] pk(input logic [8:0][7:0] w);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[71-8*i -: 8] = w[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic        pv0_q = 1'b0, pv1_q = 1'b0;
    logic [71:0] got0[$], got1[$];
    bit          fdf0[$], fdf1[$];
    int          wcyc0[$];
    int          fd_cnt0 = 0, fd_cnt1 = 0, orphan = 0, gap_viol = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pv0_q <= pv0;
        pv1_q <= pv1;
    end

    always @(negedge clk) begin
        if (win_valid0) begin
            got0.push_back(pk(wa0));
            fdf0.push_back(frame_done0);
            wcyc0.push_back(cyc);
            if (!pv0_q) gap_viol++;
        end
        if (win_valid1) begin
            got1.push_back(pk(wa1));
            fdf1.push_back(frame_done1);
            if (!pv1_q) gap_viol++;
        end
        if (frame_done0) begin fd_cnt0++; if (!win_valid0) orphan++; end
        if (frame_done1) begin fd_cnt1++; if (!win_valid1) orphan++; end
    end

    task automatic clear_mon();
        got0.delete(); got1.delete(); fdf0.delete(); fdf1.delete(); wcyc0.delete();
        fd_cnt0 = 0; fd_cnt1 = 0; orphan = 0; gap_viol = 0;
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  img [8][8];
    logic [71:0] exp_q[$];
    int          drv22_cyc;

    task automatic fill_ramp(input int base);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'(base + r*16 + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'($urandom);
    endtask

    // One window per interior centre (r,c), in raster order.
    task automatic add_expected(input int W, input int H);
        logic [71:0] e;
        for (int r = 1; r < H-1; r++)
            for (int c = 1; c < W-1; c++) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e[71-8*(3*i+j) -: 8] = img[r-1+i][c-1+j];
                exp_q.push_back(e);
            end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input bit which, input logic [7:0] p, input bit s);
        @(negedge clk);
        pv0 = !which; pix0 = p; sof0 = !which && s;
        pv1 = which;  pix1 = p; sof1 = which && s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pv0 = 1'b0; sof0 = 1'b0; pv1 = 1'b0; sof1 = 1'b0;
        end
    endtask

    task automatic send_frame(input bit which, input int W, input int H, input bit gapped);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(which, img[r][c], (r == 0 && c == 0));
                if (r == 2 && c == 2) drv22_cyc = cyc;
                if (gapped) idle(((r*W + c) % 2 == 0) ? 1 : int'($urandom_range(0, 3)));
            end
    endtask

    task automatic check_results(input string tag, input bit which, input int per_frame,
                                 input int n_frames);
        logic [71:0] got[$];
        bit          fdf[$];
        int          fdc;
        if (which) begin got = got1; fdf = fdf1; fdc = fd_cnt1; end
        else       begin got = got0; fdf = fdf0; fdc = fd_cnt0; end
        check($sformatf("%s_count", tag), 72'(got.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_win%0d", tag, i), got[i], exp_q[i]);
            check($sformatf("%s_fdflag%0d", tag, i), 72'(fdf[i]),
                  72'((i % per_frame) == per_frame - 1));
        end
        check($sformatf("%s_fdcount", tag), 72'(fdc), 72'(n_frames));
        check($sformatf("%s_orphan_fd", tag), 72'(orphan), 72'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [71:0] last_w;
        pix0 = '0; pix1 = '0; pv0 = 1'b0; pv1 = 1'b0; sof0 = 1'b0; sof1 = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_win0", pk(wa0), 72'(0));
        check("reset_flags0", {70'(0), win_valid0, frame_done0}, 72'(0));
        check("reset_win1", pk(wa1), 72'(0));
        check("reset_flags1", {70'(0), win_valid1, frame_done1}, 72'(0));
        rst_n = 1'b1;
        idle(2);

        // Stray input in IDLE, then a proper frame.
        clear_mon();
        repeat (10) send(1'b0, 8'($urandom), 1'b0);
        idle(4);
        check("stray_none", 72'(got0.size()), 72'(0));
        exp_q.delete(); fill_rand(); add_expected(4, 4);
        send_frame(1'b0, 4, 4, 1'b0);
        idle(4);
        check_results("stray_frame", 1'b0, 4, 1);

        // Ramp frame, continuous.
        clear_mon();
        exp_q.delete(); fill_ramp(0); add_expected(4, 4);
        send_frame(1'b0, 4, 4, 1'b0);
        idle(4);
        check_results("ramp", 1'b0, 4, 1);
        check("ramp_first", got0[0], 72'h00_01_02_10_11_12_20_21_22);
        check("ramp_latency", 72'(wcyc0[0]), 72'(drv22_cyc + 1));
        last_w = got0[got0.size()-1];
        check("ramp_last_centre", 72'(last_w[39:32]), 72'h22);

        // Same ramp frame with idle gaps.
        clear_mon();
        send_frame(1'b0, 4, 4, 1'b1);
        idle(4);
        check_results("gapped", 1'b0, 4, 1);
        check("gapped_after_idle", 72'(gap_viol), 72'(0));

        // sof arrives where pixel (2,1) would be; that pixel starts a new frame.
        clear_mon();
        fill_ramp(8'h80);
        for (int i = 0; i < 9; i++) send(1'b0, img[i/4][i%4], i == 0);
        exp_q.delete(); fill_rand(); add_expected(4, 4);
        send_frame(1'b0, 4, 4, 1'b0);
        idle(4);
        check_results("midsof", 1'b0, 4, 1);

        // Reset pulse mid-RUN, right after the first window was registered.
        clear_mon();
        fill_rand();
        for (int i = 0; i < 11; i++) send(1'b0, img[i/4][i%4], i == 0);
        @(negedge clk);
        pv0 = 1'b0; sof0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_win", pk(wa0), 72'(0));
        check("midrst_flags", {70'(0), win_valid0, frame_done0}, 72'(0));
        @(posedge clk); #1;
        check("midrst_win_hold", pk(wa0), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (5) send(1'b0, 8'($urandom), 1'b0);
        idle(3);
        check("midrst_ignored", 72'(got0.size()), 72'(0));
        exp_q.delete(); fill_rand(); add_expected(4, 4);
        send_frame(1'b0, 4, 4, 1'b0);
        idle(4);
        check_results("midrst_frame", 1'b0, 4, 1);

        // Back-to-back 8x5 frames; second sof lands in the DONE cycle.
        clear_mon();
        exp_q.delete();
        fill_rand(); add_expected(8, 5);
        send_frame(1'b1, 8, 5, 1'b0);
        fill_rand(); add_expected(8, 5);
        send_frame(1'b1, 8, 5, 1'b0);
        idle(4);
        check_results("b2b", 1'b1, 18, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
